// File: rtl/regfile_port_arbiter_if.sv
// Bundle of the requester-side handshake and the shared register-file port.
// The arbiter sits on the slave side; requesters and the register file drive the master side.
interface regfile_port_arbiter_if #(
  parameter int NREQ = 3,
  parameter int DW   = 16,
  parameter int AW   = 4
);
  logic [NREQ-1:0]    req;
  logic [NREQ-1:0]    req_wr;
  logic [NREQ-1:0]    req_lock;
  logic [NREQ*AW-1:0] req_id;
  logic [NREQ*DW-1:0] req_wdata;
  logic [NREQ-1:0]    gnt;
  logic [NREQ-1:0]    done;
  logic [DW-1:0]      rdata;
  logic [AW-1:0]      reg_id;
  logic               rdi;
  logic               wni;
  logic [DW-1:0]      write_data_reg;
  logic [DW-1:0]      read_data_reg;

  modport master (
    output req, req_wr, req_lock, req_id, req_wdata, read_data_reg,
    input  gnt, done, rdata, reg_id, rdi, wni, write_data_reg
  );

  modport slave (
    input  req, req_wr, req_lock, req_id, req_wdata, read_data_reg,
    output gnt, done, rdata, reg_id, rdi, wni, write_data_reg
  );
endinterface

// File: rtl/regfile_port_arbiter.sv
// Round-robin arbiter sharing one register-file port between fetch, decode and writeback.
// Each access is a short IDLE -> ISSUE -> (WAIT) -> DONE transaction; an optional lock
// keeps the port with the current owner so read-modify-write pairs are not split.
module regfile_port_arbiter #(
  parameter int NREQ = 3,
  parameter int DW   = 16,
  parameter int AW   = 4
) (
  input logic                  clk,
  input logic                  reset,
  regfile_port_arbiter_if.slave bus
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  state_t            state_q, state_d;
  logic [PW-1:0]     ptr_q, ptr_d;
  logic [PW-1:0]     owner_q, owner_d;
  logic              lock_q, lock_d;
  logic              wr_q, wr_d;
  logic [NREQ-1:0]   gnt_q, gnt_d;
  logic [NREQ-1:0]   done_q, done_d;
  logic              rdi_q, rdi_d;
  logic              wni_q, wni_d;
  logic [AW-1:0]     reg_id_q, reg_id_d;
  logic [DW-1:0]     write_data_reg_q, write_data_reg_d;
  logic [DW-1:0]     rdata_q, rdata_d;

  logic [NREQ-1:0]   eligible;
  logic              found;
  logic [PW-1:0]     win;

  function automatic logic [PW-1:0] wrap_idx(input int base, input int off);
    int s;
    s = base + off;
    if (s >= NREQ) s = s - NREQ;
    return PW'(s);
  endfunction

  // Pick the first eligible requester at or after ptr; a held lock narrows the field to the owner.
  always_comb begin
    eligible = bus.req;
    if (lock_q) eligible = bus.req & (NREQ'(1) << owner_q);
    found = 1'b0;
    win   = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (!found && eligible[wrap_idx(int'(ptr_q), i)]) begin
        found = 1'b1;
        win   = wrap_idx(int'(ptr_q), i);
      end
    end
  end

  // Next-state and next-output logic; every output is computed one cycle ahead so it leaves a flop.
  always_comb begin
    state_d          = state_q;
    ptr_d            = ptr_q;
    owner_d          = owner_q;
    lock_d           = lock_q;
    wr_d             = wr_q;
    gnt_d            = gnt_q;
    done_d           = '0;
    rdi_d            = 1'b0;
    wni_d            = 1'b0;
    reg_id_d         = reg_id_q;
    write_data_reg_d = write_data_reg_q;
    rdata_d          = rdata_q;
    case (state_q)
      IDLE: begin
        if (found) begin
          state_d     = ISSUE;
          owner_d     = win;
          ptr_d       = wrap_idx(int'(win), 1);
          wr_d        = bus.req_wr[win];
          gnt_d       = '0;
          gnt_d[win]  = 1'b1;
          reg_id_d    = bus.req_id[win*AW +: AW];
          if (bus.req_wr[win]) begin
            wni_d            = 1'b1;
            write_data_reg_d = bus.req_wdata[win*DW +: DW];
          end else begin
            rdi_d = 1'b1;
          end
        end
      end
      ISSUE: begin
        if (wr_q) begin
          state_d = DONE;
          done_d  = gnt_q;
        end else begin
          state_d = WAIT;
        end
      end
      WAIT: begin
        rdata_d = bus.read_data_reg;
        state_d = DONE;
        done_d  = gnt_q;
      end
      DONE: begin
        lock_d  = bus.req_lock[owner_q];
        state_d = IDLE;
        gnt_d   = '0;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers; reset aborts any transaction in flight without a done pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q          <= IDLE;
      ptr_q            <= '0;
      owner_q          <= '0;
      lock_q           <= 1'b0;
      wr_q             <= 1'b0;
      gnt_q            <= '0;
      done_q           <= '0;
      rdi_q            <= 1'b0;
      wni_q            <= 1'b0;
      reg_id_q         <= '0;
      write_data_reg_q <= '0;
      rdata_q          <= '0;
    end else begin
      state_q          <= state_d;
      ptr_q            <= ptr_d;
      owner_q          <= owner_d;
      lock_q           <= lock_d;
      wr_q             <= wr_d;
      gnt_q            <= gnt_d;
      done_q           <= done_d;
      rdi_q            <= rdi_d;
      wni_q            <= wni_d;
      reg_id_q         <= reg_id_d;
      write_data_reg_q <= write_data_reg_d;
      rdata_q          <= rdata_d;
    end
  end

  assign bus.gnt            = gnt_q;
  assign bus.done           = done_q;
  assign bus.rdi            = rdi_q;
  assign bus.wni            = wni_q;
  assign bus.reg_id         = reg_id_q;
  assign bus.write_data_reg = write_data_reg_q;
  assign bus.rdata          = rdata_q;

endmodule

// File: tb/tb_regfile_port_arbiter.sv
// Testbench for regfile_port_arbiter: directed scenarios plus a randomized run
// checked against a transaction-level model of round-robin arbitration with lock.
module tb_regfile_port_arbiter;

  localparam int NREQ = 3;
  localparam int DW   = 16;
  localparam int AW   = 4;
  localparam int NREG = 1 << AW;
  localparam int RN   = 400;

  logic clk   = 1'b0;
  logic reset = 1'b1;

  always #5 clk = ~clk;

  regfile_port_arbiter_if #(.NREQ(NREQ), .DW(DW), .AW(AW)) bus ();

  regfile_port_arbiter #(.NREQ(NREQ), .DW(DW), .AW(AW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks   = 0;
  int failures = 0;

  logic [DW-1:0] rf_mem [NREG];
  logic          load_en   = 1'b0;
  logic [AW-1:0] load_addr = '0;
  logic [DW-1:0] load_data = '0;

  // Register file: writes on wni, read data returned the cycle after rdi; load port lets the bench preset contents.
  always @(posedge clk) begin
    if (load_en) rf_mem[load_addr] <= load_data;
    else if (bus.wni) rf_mem[bus.reg_id] <= bus.write_data_reg;
    if (bus.rdi) bus.read_data_reg <= rf_mem[bus.reg_id];
  end

  // Expected per-cycle behaviour for the randomized run.
  logic [NREQ-1:0] e_gnt   [RN+8];
  logic [NREQ-1:0] e_done  [RN+8];
  logic            e_rdi   [RN+8];
  logic            e_wni   [RN+8];
  logic [AW-1:0]   e_id    [RN+8];
  logic [DW-1:0]   e_wdata [RN+8];
  logic [DW-1:0]   e_rdata [RN+8];
  logic            e_chk   [RN+8];
  logic [DW-1:0]   m_mem   [NREG];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idle();
    bus.req       = '0;
    bus.req_wr    = '0;
    bus.req_lock  = '0;
    bus.req_id    = '0;
    bus.req_wdata = '0;
  endtask

  task automatic load_reg(input logic [AW-1:0] a, input logic [DW-1:0] d);
    load_en   = 1'b1;
    load_addr = a;
    load_data = d;
    tick();
    load_en   = 1'b0;
  endtask

  task automatic do_reset(input int n);
    reset = 1'b1;
    repeat (n) tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    drive_idle();
    do_reset(2);
    checks++; if (bus.gnt !== 3'b000) begin failures++; $display("[TB] FAIL reset_gnt: got %b want 000", bus.gnt); end
    checks++; if (bus.done !== 3'b000) begin failures++; $display("[TB] FAIL reset_done: got %b want 000", bus.done); end
    checks++; if (bus.rdi !== 1'b0) begin failures++; $display("[TB] FAIL reset_rdi: got %b want 0", bus.rdi); end
    checks++; if (bus.wni !== 1'b0) begin failures++; $display("[TB] FAIL reset_wni: got %b want 0", bus.wni); end
    checks++; if (bus.reg_id !== 4'h0) begin failures++; $display("[TB] FAIL reset_reg_id: got %h want 0", bus.reg_id); end
    checks++; if (bus.write_data_reg !== 16'h0) begin failures++; $display("[TB] FAIL reset_wdata: got %h want 0000", bus.write_data_reg); end
    checks++; if (bus.rdata !== 16'h0) begin failures++; $display("[TB] FAIL reset_rdata: got %h want 0000", bus.rdata); end
    for (int c = 0; c < 10; c++) begin
      tick();
      checks++;
      if ({bus.gnt, bus.done, bus.rdi, bus.wni} !== 8'h00) begin
        failures++;
        $display("[TB] FAIL idle_quiet: cycle %0d got %h want 00", c, {bus.gnt, bus.done, bus.rdi, bus.wni});
      end
    end
  endtask

  task automatic test_single_write();
    drive_idle();
    bus.req                   = 3'b100;
    bus.req_wr                = 3'b100;
    bus.req_id[2*AW +: AW]    = 4'h5;
    bus.req_wdata[2*DW +: DW] = 16'h1234;
    tick();
    checks++; if (bus.gnt !== 3'b100) begin failures++; $display("[TB] FAIL wr_gnt: got %b want 100", bus.gnt); end
    checks++; if ({bus.wni, bus.rdi} !== 2'b10) begin failures++; $display("[TB] FAIL wr_strobes: got %b want 10", {bus.wni, bus.rdi}); end
    checks++; if (bus.reg_id !== 4'h5) begin failures++; $display("[TB] FAIL wr_reg_id: got %h want 5", bus.reg_id); end
    checks++; if (bus.write_data_reg !== 16'h1234) begin failures++; $display("[TB] FAIL wr_data: got %h want 1234", bus.write_data_reg); end
    checks++; if (bus.done !== 3'b000) begin failures++; $display("[TB] FAIL wr_early_done: got %b want 000", bus.done); end
    tick();
    checks++; if (bus.done !== 3'b100) begin failures++; $display("[TB] FAIL wr_done: got %b want 100", bus.done); end
    checks++; if (bus.wni !== 1'b0) begin failures++; $display("[TB] FAIL wr_wni_drop: got %b want 0", bus.wni); end
    tick();
    drive_idle();
    checks++; if ({bus.gnt, bus.done} !== 6'b0) begin failures++; $display("[TB] FAIL wr_release: got %b want 000000", {bus.gnt, bus.done}); end
    checks++; if (rf_mem[5] !== 16'h1234) begin failures++; $display("[TB] FAIL wr_regfile: got %h want 1234", rf_mem[5]); end
    tick();
  endtask

  task automatic test_single_read();
    load_reg(4'h0, 16'h00A0);
    drive_idle();
    bus.req = 3'b001;
    tick();
    checks++; if ({bus.rdi, bus.wni} !== 2'b10) begin failures++; $display("[TB] FAIL rd_strobes: got %b want 10", {bus.rdi, bus.wni}); end
    checks++; if (bus.gnt !== 3'b001) begin failures++; $display("[TB] FAIL rd_gnt: got %b want 001", bus.gnt); end
    checks++; if (bus.reg_id !== 4'h0) begin failures++; $display("[TB] FAIL rd_reg_id: got %h want 0", bus.reg_id); end
    tick();
    checks++; if ({bus.rdi, bus.done} !== 4'b0) begin failures++; $display("[TB] FAIL rd_wait: got %b want 0000", {bus.rdi, bus.done}); end
    tick();
    checks++; if (bus.done !== 3'b001) begin failures++; $display("[TB] FAIL rd_done: got %b want 001", bus.done); end
    checks++; if (bus.rdata !== 16'h00A0) begin failures++; $display("[TB] FAIL rd_rdata: got %h want 00a0", bus.rdata); end
    tick();
    drive_idle();
    checks++; if (bus.rdata !== 16'h00A0) begin failures++; $display("[TB] FAIL rd_hold: got %h want 00a0", bus.rdata); end
    tick();
  endtask

  task automatic test_rotation();
    int            d_cyc [$];
    logic [2:0]    d_val [$];
    logic [DW-1:0] d_dat [$];
    int            x_cyc [4] = '{3, 7, 11, 15};
    logic [2:0]    x_val [4] = '{3'b001, 3'b010, 3'b100, 3'b001};
    logic [DW-1:0] x_dat [4] = '{16'h1111, 16'h2222, 16'h3333, 16'h1111};
    int            overlap = 0;
    load_reg(4'h1, 16'h1111);
    load_reg(4'h2, 16'h2222);
    load_reg(4'h3, 16'h3333);
    drive_idle();
    do_reset(2);
    bus.req    = 3'b111;
    bus.req_id = {4'd3, 4'd2, 4'd1};
    for (int c = 1; c <= 16; c++) begin
      tick();
      if (bus.rdi && bus.wni) overlap++;
      if (bus.done !== 3'b000) begin
        d_cyc.push_back(c);
        d_val.push_back(bus.done);
        d_dat.push_back(bus.rdata);
      end
    end
    drive_idle();
    checks++; if (overlap !== 0) begin failures++; $display("[TB] FAIL rot_overlap: got %0d want 0", overlap); end
    checks++; if (d_cyc.size() !== 4) begin failures++; $display("[TB] FAIL rot_count: got %0d want 4", d_cyc.size()); end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (i >= d_cyc.size()) begin
        failures++; $display("[TB] FAIL rot_done%0d: got none want %b@%0d", i, x_val[i], x_cyc[i]);
      end else if (d_cyc[i] !== x_cyc[i] || d_val[i] !== x_val[i] || d_dat[i] !== x_dat[i]) begin
        failures++;
        $display("[TB] FAIL rot_done%0d: got %b@%0d data %h want %b@%0d data %h",
                 i, d_val[i], d_cyc[i], d_dat[i], x_val[i], x_cyc[i], x_dat[i]);
      end
    end
    tick();
    tick();
  endtask

  task automatic test_lock_rmw();
    logic [2:0]    seq [$];
    logic [2:0]    x_seq [3] = '{3'b001, 3'b001, 3'b010};
    logic [DW-1:0] saved = '0;
    int            phase = 0;
    int            intrude = 0;
    logic          upd = 1'b0;
    logic          drop = 1'b0;
    load_reg(4'h0, 16'h0041);
    drive_idle();
    do_reset(2);
    bus.req      = 3'b111;
    bus.req_lock = 3'b001;
    bus.req_id   = {4'd3, 4'd2, 4'd0};
    for (int c = 0; c < 40 && seq.size() < 3; c++) begin
      tick();
      if (upd) begin
        bus.req_wr[0]          = 1'b1;
        bus.req_wdata[DW-1:0]  = saved + 16'd1;
        bus.req_lock[0]        = 1'b0;
        upd = 1'b0;
      end
      if (drop) begin
        bus.req[0] = 1'b0;
        drop = 1'b0;
      end
      if (phase < 2 && bus.gnt !== 3'b000 && bus.gnt !== 3'b001) intrude++;
      if (bus.done !== 3'b000) begin
        seq.push_back(bus.done);
        if (bus.done === 3'b001 && phase == 0) begin
          saved = bus.rdata; upd = 1'b1; phase = 1;
        end else if (bus.done === 3'b001 && phase == 1) begin
          drop = 1'b1; phase = 2;
        end
        if (seq.size() == 3) drive_idle();
      end
    end
    drive_idle();
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (i >= seq.size()) begin
        failures++; $display("[TB] FAIL lock_seq%0d: got none want %b", i, x_seq[i]);
      end else if (seq[i] !== x_seq[i]) begin
        failures++; $display("[TB] FAIL lock_seq%0d: got %b want %b", i, seq[i], x_seq[i]);
      end
    end
    checks++; if (intrude !== 0) begin failures++; $display("[TB] FAIL lock_intrude: got %0d want 0", intrude); end
    checks++; if (saved !== 16'h0041) begin failures++; $display("[TB] FAIL lock_read: got %h want 0041", saved); end
    checks++; if (rf_mem[0] !== 16'h0042) begin failures++; $display("[TB] FAIL lock_write: got %h want 0042", rf_mem[0]); end
    tick();
    tick();
  endtask

  task automatic test_reset_mid_read();
    load_reg(4'h4, 16'h4444);
    drive_idle();
    do_reset(2);
    bus.req      = 3'b010;
    bus.req_lock = 3'b010;
    bus.req_id   = {4'd0, 4'd4, 4'd0};
    repeat (3) tick();
    checks++; if ({bus.done, bus.rdata} !== {3'b010, 16'h4444}) begin failures++; $display("[TB] FAIL mid_first_done: got %b %h want 010 4444", bus.done, bus.rdata); end
    repeat (2) tick();
    checks++; if ({bus.rdi, bus.gnt} !== 4'b1010) begin failures++; $display("[TB] FAIL mid_second_issue: got %b want 1010", {bus.rdi, bus.gnt}); end
    tick();
    checks++; if ({bus.rdi, bus.done} !== 4'b0000) begin failures++; $display("[TB] FAIL mid_wait: got %b want 0000", {bus.rdi, bus.done}); end
    reset        = 1'b1;
    bus.req      = 3'b101;
    bus.req_lock = 3'b000;
    bus.req_id   = {4'd0, 4'd0, 4'd1};
    tick();
    reset = 1'b0;
    checks++; if ({bus.gnt, bus.done, bus.rdi, bus.wni} !== 8'h00) begin failures++; $display("[TB] FAIL mid_ctrl: got %h want 00", {bus.gnt, bus.done, bus.rdi, bus.wni}); end
    checks++; if ({bus.reg_id, bus.write_data_reg, bus.rdata} !== 36'h0) begin failures++; $display("[TB] FAIL mid_data: got %h want 0", {bus.reg_id, bus.write_data_reg, bus.rdata}); end
    tick();
    checks++; if (bus.gnt !== 3'b001) begin failures++; $display("[TB] FAIL mid_restart_gnt: got %b want 001", bus.gnt); end
    repeat (2) tick();
    checks++; if (bus.done !== 3'b001) begin failures++; $display("[TB] FAIL mid_restart_done: got %b want 001", bus.done); end
    tick();
    drive_idle();
    tick();
    tick();
  endtask

  task automatic test_random();
    logic [NREQ-1:0] p_pend;
    logic            p_wr   [NREQ];
    logic            p_lock [NREQ];
    logic [AW-1:0]   p_id   [NREQ];
    logic [DW-1:0]   p_data [NREQ];
    int              fin    [NREQ];
    int              m_ptr, m_owner, next_dec, w, d, cand, bad;
    logic            m_lock, found;
    logic [NREQ-1:0] elig;
    logic [DW-1:0]   v;
    for (int c = 0; c < RN + 8; c++) begin
      e_gnt[c] = '0; e_done[c] = '0; e_rdi[c] = 1'b0; e_wni[c] = 1'b0;
      e_id[c] = '0; e_wdata[c] = '0; e_rdata[c] = '0; e_chk[c] = 1'b0;
    end
    drive_idle();
    for (int i = 0; i < NREG; i++) begin
      v = DW'($urandom);
      m_mem[i] = v;
      load_reg(AW'(i), v);
    end
    p_pend = '0;
    for (int k = 0; k < NREQ; k++) begin
      p_wr[k] = 1'b0; p_lock[k] = 1'b0; p_id[k] = '0; p_data[k] = '0; fin[k] = -1;
    end
    m_ptr = 0; m_owner = 0; m_lock = 1'b0; next_dec = 0;
    do_reset(1);
    for (int t = 0; t < RN; t++) begin
      checks++;
      if ({bus.gnt, bus.done, bus.rdi, bus.wni} !== {e_gnt[t], e_done[t], e_rdi[t], e_wni[t]}) begin
        failures++;
        $display("[TB] FAIL rand_ctrl: cycle %0d got gnt=%b done=%b rdi=%b wni=%b want gnt=%b done=%b rdi=%b wni=%b",
                 t, bus.gnt, bus.done, bus.rdi, bus.wni, e_gnt[t], e_done[t], e_rdi[t], e_wni[t]);
      end
      if (e_rdi[t] || e_wni[t]) begin
        checks++;
        if (bus.reg_id !== e_id[t]) begin failures++; $display("[TB] FAIL rand_reg_id: cycle %0d got %h want %h", t, bus.reg_id, e_id[t]); end
      end
      if (e_wni[t]) begin
        checks++;
        if (bus.write_data_reg !== e_wdata[t]) begin failures++; $display("[TB] FAIL rand_wdata: cycle %0d got %h want %h", t, bus.write_data_reg, e_wdata[t]); end
      end
      if (e_chk[t]) begin
        checks++;
        if (bus.rdata !== e_rdata[t]) begin failures++; $display("[TB] FAIL rand_rdata: cycle %0d got %h want %h", t, bus.rdata, e_rdata[t]); end
      end
      // Requesters: a finished locked owner must follow up; others start new work at random.
      for (int k = 0; k < NREQ; k++) begin
        if (fin[k] == t || (!p_pend[k] && $urandom_range(0, 2) == 0)) begin
          p_pend[k] = (fin[k] == t && p_lock[k]) ? 1'b1 :
                      (fin[k] == t) ? 1'($urandom_range(0, 1)) : 1'b1;
          p_wr[k]   = 1'($urandom_range(0, 1));
          p_lock[k] = ($urandom_range(0, 3) == 0);
          p_id[k]   = AW'($urandom_range(0, NREG - 1));
          p_data[k] = DW'($urandom);
          fin[k]    = -1;
        end
        bus.req[k]                = p_pend[k];
        bus.req_wr[k]             = p_wr[k];
        bus.req_lock[k]           = p_lock[k];
        bus.req_id[k*AW +: AW]    = p_id[k];
        bus.req_wdata[k*DW +: DW] = p_data[k];
      end
      // Model: at each free arbitration slot pick the round-robin winner and schedule its transaction.
      if (t == next_dec) begin
        elig  = m_lock ? (p_pend & (NREQ'(1) << m_owner)) : p_pend;
        found = 1'b0;
        w     = 0;
        for (int i = 0; i < NREQ; i++) begin
          cand = (m_ptr + i) % NREQ;
          if (!found && elig[cand]) begin found = 1'b1; w = cand; end
        end
        if (found) begin
          d = t + (p_wr[w] ? 2 : 3);
          for (int c = t + 1; c <= d; c++) e_gnt[c] = NREQ'(1) << w;
          e_done[d]  = NREQ'(1) << w;
          e_id[t+1]  = p_id[w];
          if (p_wr[w]) begin
            e_wni[t+1]   = 1'b1;
            e_wdata[t+1] = p_data[w];
            m_mem[p_id[w]] = p_data[w];
          end else begin
            e_rdi[t+1] = 1'b1;
            e_rdata[d] = m_mem[p_id[w]];
            e_chk[d]   = 1'b1;
          end
          m_ptr    = (w + 1) % NREQ;
          m_lock   = p_lock[w];
          m_owner  = w;
          fin[w]   = d + 1;
          next_dec = d + 1;
        end else begin
          next_dec = t + 1;
        end
      end
      tick();
    end
    drive_idle();
    repeat (6) tick();
    bad = 0;
    for (int i = 0; i < NREG; i++) if (rf_mem[i] !== m_mem[i]) bad++;
    checks++;
    if (bad !== 0) begin failures++; $display("[TB] FAIL rand_regfile: got %0d differing entries want 0", bad); end
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_single_read();
    test_rotation();
    test_lock_rmw();
    test_reset_mid_read();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Watchdog so the run always ends even if a scenario stalls.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/regfile_port_arbiter.md
Name: regfile_port_arbiter

Overview:
- Shares the single register-file access port (reg_id / rdi / wni / write_data_reg / read_data_reg) between several pipeline requesters: fetch (PC read and increment), decode (operand reads) and writeback.
- Each access is a short sequenced transaction with a one-hot grant and a done pulse.
- An optional lock keeps the port with one requester for read-modify-write sequences, such as the PC read followed by the PC+1 write in fetch.

Parameters:
NREQ, 3, number of requesters (0 = fetch, 1 = decode, 2 = writeback)
DW, 16, register data width
AW, 4, register index width

Ports:
clk  input  1  clock, all state changes on posedge
reset  input  1  synchronous, active-high reset
req  input  NREQ  per-requester access request, held until that requester's done
req_wr  input  NREQ  1 = write, 0 = read; sampled at grant
req_lock  input  NREQ  keep ownership after this transaction; sampled in DONE
req_id  input  NREQ*AW  packed register index; requester k uses bits [k*AW +: AW]
req_wdata  input  NREQ*DW  packed write data; requester k uses bits [k*DW +: DW]
gnt  output  NREQ  one-hot, owner of the current transaction
done  output  NREQ  one-cycle pulse to the owner; marks transaction complete
rdata  output  DW  read result; valid while done is high, held until the next read
reg_id  output  AW  register file index
rdi  output  1  register file read strobe
wni  output  1  register file write strobe
write_data_reg  output  DW  register file write data
read_data_reg  input  DW  register file read data, valid the cycle after rdi

Behaviour:
- All outputs are registered.
- On reset:
  - state = IDLE, ptr = 0, lock = 0.
  - gnt, done, rdi, wni = 0.
  - reg_id = 0, write_data_reg = 0, rdata = 0.
- Reset mid-transaction aborts it on that edge: strobes drop, and no done is issued.
- States: IDLE, ISSUE, WAIT, DONE.
- IDLE:
  - Eligible set is req, or only req[owner] when lock = 1.
  - Round-robin search starts at ptr.
  - On a winner w: latch owner = w, plus its req_wr, req_id and req_wdata.
  - Set gnt = one-hot(w), ptr = (w+1) mod NREQ, go to ISSUE.
  - With no eligible request: stay in IDLE with all strobes 0.
- ISSUE (1 cycle):
  - reg_id = latched id.
  - Write: wni = 1, rdi = 0, write_data_reg = latched data; next state DONE.
  - Read: rdi = 1, wni = 0; next state WAIT.
  - rdi and wni are never high together.
- WAIT (reads only):
  - Strobes 0.
  - rdata <= read_data_reg at the end of the cycle; go to DONE.
- DONE (1 cycle):
  - done[owner] = 1, strobes 0, gnt still asserted.
  - lock <= req_lock[owner].
  - Then IDLE with gnt cleared.
- Latency from req sampled in IDLE (cycle 0):
  - Write: wni in cycle 1, done in cycle 2.
  - Read: rdi in cycle 1, done and rdata in cycle 3.
  - Back-to-back throughput: one write per 3 cycles, one read per 4 cycles.
- Requester protocol:
  - Deassert or update req on the edge that ends the done cycle.
  - A req still high in the following IDLE is a new request.
- Lock:
  - While lock = 1, other requesters stall indefinitely.
  - Lock clears when the owner completes a transaction with req_lock = 0.
  - If the owner drops req while locked, the arbiter stays in IDLE with lock = 1. Fetch must always release.
- Simultaneous requests: resolved by the ptr order only; there is no fixed priority.
- Requests arriving during ISSUE, WAIT or DONE wait for the next IDLE.
- Index and data bits are passed through unmodified; no range checks.

Test Plan:
- Reset then idle: reset for 2 cycles, no req -> all outputs 0, state IDLE, no strobes for 10 cycles.
- Single write: req = 3'b100, wr = 1, id = 4'h5, wdata = 16'h1234 -> cycle 1: gnt = 100, wni = 1, reg_id = 5, write_data_reg = 1234; cycle 2: done = 100.
- Single read: req = 3'b001, wr = 0, id = 0, regfile returns 16'h00A0 -> rdi in cycle 1; done = 001 and rdata = 00A0 in cycle 3.
- Contention and rotation: all three request reads continuously from reset (ptr = 0) -> grants in order 001, 010, 100, 001; each done 4 cycles apart, with no overlap of strobes.
- Lock for fetch RMW:
  - Fetch issues a read of reg 0 (lock = 1), then a write of reg 0 = old+1 (lock = 0), while decode and writeback hold req.
  - Required: both fetch transactions complete back-to-back, no other gnt in between, decode granted next.
- Reset mid-read: assert reset during WAIT -> next cycle all outputs 0, no done pulse, lock = 0, arbitration restarts at ptr = 0.
